// File: rtl/sign_restore_out.sv
// Output stage of the signed multiplier: queues product signs at operand load
// and applies them to the unsigned magnitudes returned by the multiplier core.
module sign_restore_out #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               x_sign,
  input  logic               y_sign,
  input  logic               sign_push,
  input  logic [2*WIDTH-1:0] mag_in,
  input  logic               mag_valid,
  output logic [2*WIDTH-1:0] p_out,
  output logic               p_valid,
  output logic               full,
  output logic               empty,
  output logic               err_overflow,
  output logic               err_underflow
);

  localparam int MW = 2 * WIDTH;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [MW-1:0] MAG_ONE = {{(MW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic             sign_mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [MW-1:0]    p_out_r;
  logic             p_valid_r;
  logic             err_ovf_r;
  logic             err_unf_r;

  logic             clear_s;
  logic             empty_s;
  logic             full_s;
  logic             pop_ok_s;
  logic             push_ok_s;
  logic             pop_sign_s;
  logic [CW-1:0]    count_nxt_s;
  logic [MW-1:0]    signed_mag_s;

  // Queue status, push/pop qualification and sign application.
  always_comb begin
    clear_s      = reset | ~enable;
    empty_s      = (count_r == {CW{1'b0}});
    full_s       = (count_r == CNT_FULL);
    // A pop frees a slot in the same edge, so a push on a full queue still lands.
    pop_ok_s     = mag_valid & ~empty_s;
    push_ok_s    = sign_push & (~full_s | pop_ok_s);
    pop_sign_s   = sign_mem_r[rd_ptr_r];
    signed_mag_s = pop_sign_s ? (~mag_in + MAG_ONE) : mag_in;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Sign storage; contents need no clear since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s && !clear_s) begin
      sign_mem_r[wr_ptr_r] <= x_sign ^ y_sign;
    end
  end

  // Pointers, occupancy, product register and sticky error flags.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      count_r   <= {CW{1'b0}};
      p_out_r   <= {MW{1'b0}};
      p_valid_r <= 1'b0;
      err_ovf_r <= 1'b0;
      err_unf_r <= 1'b0;
    end else begin
      wr_ptr_r  <= push_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r  <= pop_ok_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      count_r   <= count_nxt_s;
      p_out_r   <= pop_ok_s ? signed_mag_s : p_out_r;
      p_valid_r <= pop_ok_s;
      err_ovf_r <= err_ovf_r | (sign_push & full_s & ~pop_ok_s);
      err_unf_r <= err_unf_r | (mag_valid & empty_s);
    end
  end

  assign p_out         = p_out_r;
  assign p_valid       = p_valid_r;
  assign full          = (count_r == CNT_FULL);
  assign empty         = (count_r == {CW{1'b0}});
  assign err_overflow  = err_ovf_r;
  assign err_underflow = err_unf_r;

endmodule

// File: tb/tb_sign_restore_out.sv
// Self-checking bench for sign_restore_out: directed scenarios plus a random
// run, all scored against a queue-based model of the sign FIFO.
module tb_sign_restore_out;

  localparam int WIDTH = 12;
  localparam int DEPTH = 4;
  localparam int MW    = 2 * WIDTH;

  logic          clk = 1'b0;
  logic          reset, enable, x_sign, y_sign, sign_push, mag_valid;
  logic [MW-1:0] mag_in;
  logic [MW-1:0] p_out;
  logic          p_valid, full, empty, err_overflow, err_underflow;

  int vectors = 0;
  int miscompares = 0;

  bit            sq[$];
  logic [MW-1:0] exp_p;
  logic          exp_v, exp_ovf, exp_unf;

  sign_restore_out #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .x_sign(x_sign), .y_sign(y_sign),
    .sign_push(sign_push), .mag_in(mag_in), .mag_valid(mag_valid), .p_out(p_out),
    .p_valid(p_valid), .full(full), .empty(empty), .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit push, input bit xs, input bit ys, input bit pop,
                            input logic [MW-1:0] mag, input bit rst, input bit en);
    int  pre_n;
    bit  pop_ok;
    bit  s;
    if (rst || !en) begin
      sq.delete();
      exp_p = '0; exp_v = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    end else begin
      pre_n  = sq.size();
      pop_ok = pop && (pre_n > 0);
      exp_v  = 1'b0;
      if (pop && pre_n == 0) exp_unf = 1'b1;
      if (pop_ok) begin
        s     = sq.pop_front();
        exp_p = s ? (MW'(0) - mag) : mag;
        exp_v = 1'b1;
      end
      if (push) begin
        if (pre_n < DEPTH || pop_ok) sq.push_back(xs ^ ys);
        else exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit push, input bit xs, input bit ys, input bit pop,
                       input logic [MW-1:0] mag, input bit rst, input bit en);
    sign_push = push; x_sign = xs; y_sign = ys; mag_valid = pop; mag_in = mag;
    reset = rst; enable = en;
    model_step(push, xs, ys, pop, mag, rst, en);
    @(posedge clk); #1;
    sign_push = 1'b0; mag_valid = 1'b0; reset = 1'b0; enable = 1'b1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (p_out !== 24'h000000) begin miscompares++; $display("FAIL reset_p_out got=%h exp=000000", p_out); end
    vectors++; if (p_valid !== 1'b0) begin miscompares++; $display("FAIL reset_p_valid got=%b exp=0", p_valid); end
    vectors++; if ({empty, full} !== 2'b10) begin miscompares++; $display("FAIL reset_flags empty,full got=%b exp=10", {empty, full}); end
    vectors++; if ({err_overflow, err_underflow} !== 2'b00) begin miscompares++; $display("FAIL reset_errs got=%b exp=00", {err_overflow, err_underflow}); end
  endtask

  task automatic test_sign_mix();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h000006, 1'b0, 1'b1);
    vectors++; if (p_valid !== 1'b1 || p_out !== 24'hFFFFFA) begin miscompares++; $display("FAIL sign_mix_neg got=%b/%h exp=1/fffffa", p_valid, p_out); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    vectors++; if (p_valid !== 1'b0 || p_out !== 24'hFFFFFA) begin miscompares++; $display("FAIL sign_mix_hold got=%b/%h exp=0/fffffa", p_valid, p_out); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h400000, 1'b0, 1'b1);
    vectors++; if (p_valid !== 1'b1 || p_out !== 24'h400000) begin miscompares++; $display("FAIL sign_mix_pos got=%b/%h exp=1/400000", p_valid, p_out); end
  endtask

  task automatic test_in_order();
    logic [MW-1:0] want [4];
    logic [3:0]    xs_v, ys_v;
    want[0] = 24'h000005; want[1] = 24'hFFFFFB; want[2] = 24'hFFFFFB; want[3] = 24'h000005;
    xs_v = 4'b1010; ys_v = 4'b1100;
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, xs_v[i], ys_v[i], 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h000005, 1'b0, 1'b1);
      vectors++; if (p_valid !== 1'b1 || p_out !== want[i]) begin miscompares++; $display("FAIL in_order[%0d] got=%b/%h exp=1/%h", i, p_valid, p_out, want[i]); end
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL in_order_empty got=%b exp=1", empty); end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, i[0], 1'b0, 1'b0, '0, 1'b0, 1'b1);
    vectors++; if (full !== 1'b1 || err_overflow !== 1'b0) begin miscompares++; $display("FAIL full_after4 full,ovf got=%b%b exp=10", full, err_overflow); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    vectors++; if (err_overflow !== 1'b1 || full !== 1'b1) begin miscompares++; $display("FAIL overflow ovf,full got=%b%b exp=11", err_overflow, full); end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 24'h000007, 1'b0, 1'b1);
    vectors++; if (p_valid !== 1'b1 || p_out !== 24'h000007 || full !== 1'b1) begin miscompares++; $display("FAIL full_push_pop got=%b/%h/%b exp=1/000007/1", p_valid, p_out, full); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h000010 + MW'(i), 1'b0, 1'b1);
      vectors++; if (p_valid !== exp_v || p_out !== exp_p) begin miscompares++; $display("FAIL drain[%0d] got=%b/%h exp=%b/%h", i, p_valid, p_out, exp_v, exp_p); end
    end
    vectors++; if (empty !== 1'b1 || err_overflow !== 1'b1) begin miscompares++; $display("FAIL drained empty,ovf got=%b%b exp=11", empty, err_overflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h000003, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h000009, 1'b0, 1'b1);
    vectors++; if (p_valid !== 1'b0 || p_out !== 24'hFFFFFD || err_underflow !== 1'b1) begin miscompares++; $display("FAIL underflow got=%b/%h/%b exp=0/fffffd/1", p_valid, p_out, err_underflow); end
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 24'h000002, 1'b0, 1'b1);
    vectors++; if (err_underflow !== 1'b1 || p_valid !== 1'b0 || empty !== 1'b0 || full !== 1'b0) begin miscompares++; $display("FAIL empty_push_pop unf,pv,empty,full got=%b%b%b%b exp=1000", err_underflow, p_valid, empty, full); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h000002, 1'b0, 1'b1);
    vectors++; if (p_valid !== 1'b1 || p_out !== 24'hFFFFFE || empty !== 1'b1) begin miscompares++; $display("FAIL count1_pop got=%b/%h/%b exp=1/fffffe/1", p_valid, p_out, empty); end
  endtask

  task automatic test_extremes();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 24'h000000, 1'b0, 1'b1);
    vectors++; if (p_valid !== 1'b1 || p_out !== 24'h000000) begin miscompares++; $display("FAIL neg_zero got=%b/%h exp=1/000000", p_valid, p_out); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h400000, 1'b0, 1'b1);
    vectors++; if (p_valid !== 1'b1 || p_out !== 24'hC00000) begin miscompares++; $display("FAIL neg_max got=%b/%h exp=1/c00000", p_valid, p_out); end
  endtask

  task automatic test_reset_mid(input bit use_enable);
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h000001, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 24'h000004, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h000008, !use_enable, !use_enable ? 1'b1 : 1'b0);
    vectors++; if (p_valid !== 1'b0 || p_out !== 24'h000000 || empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL reset_mid[en=%0d] got=%b/%h/%b%b exp=0/000000/10", use_enable, p_valid, p_out, empty, full); end
    vectors++; if ({err_overflow, err_underflow} !== 2'b00) begin miscompares++; $display("FAIL reset_mid_errs[en=%0d] got=%b exp=00", use_enable, {err_overflow, err_underflow}); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 24'h000003, 1'b0, 1'b1);
    vectors++; if (p_valid !== 1'b1 || p_out !== 24'hFFFFFD) begin miscompares++; $display("FAIL after_reset_pop1 got=%b/%h exp=1/fffffd", p_valid, p_out); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h000003, 1'b0, 1'b1);
    vectors++; if (p_valid !== 1'b1 || p_out !== 24'h000003 || empty !== 1'b1) begin miscompares++; $display("FAIL after_reset_pop2 got=%b/%h/%b exp=1/000003/1", p_valid, p_out, empty); end
  endtask

  task automatic test_random();
    bit            push, pop, rst, en;
    logic [MW-1:0] mag;
    int            bad;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      push = ($urandom_range(0, 99) < 55);
      pop  = ($urandom_range(0, 99) < 50);
      rst  = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 199) != 0);
      mag  = ($urandom_range(0, 9) == 0) ? MW'(0) : MW'($urandom);
      drive(push, 1'($urandom), 1'($urandom), pop, mag, rst, en);
      bad = 0;
      if (p_valid !== exp_v) bad++;
      if (p_out !== exp_p) bad++;
      if (empty !== (sq.size() == 0)) bad++;
      if (full !== (sq.size() == DEPTH)) bad++;
      if (err_overflow !== exp_ovf) bad++;
      if (err_underflow !== exp_unf) bad++;
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL random[%0d] got pv=%b p=%h e=%b f=%b ovf=%b unf=%b exp pv=%b p=%h e=%b f=%b ovf=%b unf=%b",
                 n, p_valid, p_out, empty, full, err_overflow, err_underflow,
                 exp_v, exp_p, sq.size() == 0, sq.size() == DEPTH, exp_ovf, exp_unf);
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; x_sign = 1'b0; y_sign = 1'b0;
    sign_push = 1'b0; mag_valid = 1'b0; mag_in = '0;
    exp_p = '0; exp_v = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_sign_mix();
    test_in_order();
    test_full_overflow();
    test_underflow();
    test_extremes();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
